// File: rtl/reg_bank_viewer.sv
// reg_bank_viewer: read-side viewer for the 16x16 register bank.
// Steps a read address through the bank, either on a debounced key press
// or on an automatic scan timer. It formats address and data into a
// nibble-packed word for eight decode_HEX digits, plus a digit-enable mask.
module reg_bank_viewer #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 16,
    parameter int DEBOUNCE_CYC = 4,
    parameter int SCAN_PERIOD  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              key_next,
    input  logic              key_mode,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [31:0]       display,
    output logic [7:0]        modo,
    output logic              auto_led
);

    // Counter widths and terminal values
    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

    // Key indices inside the two-bit key vectors
    localparam int K_NEXT = 0;
    localparam int K_MODE = 1;

    // Digit-enable pattern after a capture: HEX5/HEX4 stay dark
    localparam logic [7:0] MODO_SHOW = 8'b1100_1111;

    typedef enum logic [1:0] {
        ST_SETUP   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    // Top display nibble marks auto mode with an 'A'
    function automatic logic [3:0] mode_nibble(input logic auto_mode);
        logic [3:0] nib;
        if (auto_mode) begin
            nib = 4'hA;
        end else begin
            nib = 4'h0;
        end
        return nib;
    endfunction

    // Address step, wrapping naturally at the bank depth
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return addr + ADDR_W'(1);
    endfunction

    // Key path state (index 0 = key_next, index 1 = key_mode)
    logic [1:0]      key_raw_s;
    logic [1:0]      key_meta_r;
    logic [1:0]      key_sync_r;
    logic [1:0]      key_level_r;
    logic [1:0]      key_press_r;
    logic [DB_W-1:0] db_cnt_r [2];

    // Mode and scan timer
    logic              mode_r;
    logic [SCAN_W-1:0] scan_cnt_r;
    logic              mode_press_s;
    logic              next_press_s;
    logic              scan_hit_s;
    logic              adv_req_s;

    // FSM state and registered outputs
    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] cur_addr_nxt_s;
    logic              pending_r;
    logic              pending_nxt_s;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [ADDR_W-1:0] rd_addr_nxt_s;
    logic [31:0]       display_r;
    logic [31:0]       display_nxt_s;
    logic [7:0]        modo_r;
    logic [7:0]        modo_nxt_s;
    logic [15:0]       data16_s;
    logic [3:0]        addr4_s;

    assign key_raw_s = {key_mode, key_next};

    // Two-flop synchronizer for both raw keys; idle level is released (1)
    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_r <= 2'b11;
            key_sync_r <= 2'b11;
        end else begin
            key_meta_r <= key_raw_s;
            key_sync_r <= key_meta_r;
        end
    end

    // Debounce each key on tick; flag a one-clk press on an accepted 1->0
    always_ff @(posedge clk) begin
        if (reset) begin
            key_level_r <= 2'b11;
            key_press_r <= 2'b00;
            db_cnt_r[0] <= {DB_W{1'b0}};
            db_cnt_r[1] <= {DB_W{1'b0}};
        end else begin
            for (int k = 0; k < 2; k++) begin
                key_press_r[k] <= 1'b0;
                if (key_sync_r[k] == key_level_r[k]) begin
                    db_cnt_r[k] <= {DB_W{1'b0}};
                end else if (tick) begin
                    if ((db_cnt_r[k] + DB_W'(1)) == DB_LAST) begin
                        key_level_r[k] <= ~key_level_r[k];
                        db_cnt_r[k]    <= {DB_W{1'b0}};
                        // old level 1 means this flip is a press, not a release
                        key_press_r[k] <= key_level_r[k];
                    end else begin
                        db_cnt_r[k] <= db_cnt_r[k] + DB_W'(1);
                    end
                end else begin
                    db_cnt_r[k] <= db_cnt_r[k];
                end
            end
        end
    end

    assign mode_press_s = key_press_r[K_MODE];
    assign next_press_s = key_press_r[K_NEXT];
    assign scan_hit_s   = mode_r & tick & (scan_cnt_r == SCAN_LAST);

    // Manual/auto mode toggle on a key_mode press
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_r <= 1'b0;
        end else if (mode_press_s) begin
            mode_r <= ~mode_r;
        end else begin
            mode_r <= mode_r;
        end
    end

    // Scan timer: held at zero in manual, so entering auto starts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
        end else if (!mode_r) begin
            scan_cnt_r <= {SCAN_W{1'b0}};
        end else if (tick) begin
            if (scan_cnt_r == SCAN_LAST) begin
                scan_cnt_r <= {SCAN_W{1'b0}};
            end else begin
                scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
            end
        end else begin
            scan_cnt_r <= scan_cnt_r;
        end
    end

    // Advance request: the scan timer in auto, key_next in manual; a
    // simultaneous key_mode press wins over key_next
    always_comb begin
        adv_req_s = 1'b0;
        if (mode_r) begin
            adv_req_s = scan_hit_s;
        end else begin
            adv_req_s = next_press_s & ~mode_press_s;
        end
    end

    assign data16_s = 16'(rd_data);
    assign addr4_s  = 4'(cur_addr_r);

    // FSM next state plus next values of the registered outputs
    always_comb begin
        state_nxt_s    = state_r;
        cur_addr_nxt_s = cur_addr_r;
        pending_nxt_s  = pending_r;
        rd_addr_nxt_s  = rd_addr_r;
        display_nxt_s  = display_r;
        modo_nxt_s     = modo_r;
        case (state_r)
            ST_SHOW: begin
                // keep the data field live and the mode nibble current
                display_nxt_s = {mode_nibble(mode_r), display_r[27:16], data16_s};
                if (adv_req_s || pending_r) begin
                    cur_addr_nxt_s = next_addr(cur_addr_r);
                    pending_nxt_s  = 1'b0;
                    state_nxt_s    = ST_SETUP;
                end else begin
                    state_nxt_s    = ST_SHOW;
                end
            end
            ST_SETUP: begin
                rd_addr_nxt_s = cur_addr_r;
                if (adv_req_s) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                state_nxt_s = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                display_nxt_s = {mode_nibble(mode_r), addr4_s, 8'h00, data16_s};
                modo_nxt_s    = MODO_SHOW;
                if (adv_req_s) begin
                    pending_nxt_s = 1'b1;
                end else begin
                    pending_nxt_s = pending_r;
                end
                state_nxt_s = ST_SHOW;
            end
            default: begin
                // unreachable encoding: restart from a fresh address setup
                pending_nxt_s = 1'b0;
                state_nxt_s   = ST_SETUP;
            end
        endcase
    end

    // FSM state, address bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_SETUP;
            cur_addr_r <= {ADDR_W{1'b0}};
            pending_r  <= 1'b0;
            rd_addr_r  <= {ADDR_W{1'b0}};
            display_r  <= 32'h0000_0000;
            modo_r     <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            cur_addr_r <= cur_addr_nxt_s;
            pending_r  <= pending_nxt_s;
            rd_addr_r  <= rd_addr_nxt_s;
            display_r  <= display_nxt_s;
            modo_r     <= modo_nxt_s;
        end
    end

    assign rd_addr  = rd_addr_r;
    assign display  = display_r;
    assign modo     = modo_r;
    assign auto_led = mode_r;

endmodule

// File: tb/tb_reg_bank_viewer.sv
// Directed testbench for reg_bank_viewer: a behavioural register bank feeds
// rd_data. Keys are driven with clean presses or bounces, and outputs are
// compared with hand-derived values on the falling clock edge.
module tb_reg_bank_viewer;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        key_next;
    logic        key_mode;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [31:0] display;
    logic [7:0]  modo;
    logic        auto_led;

    logic [15:0] bank [16];

    int check_cnt = 0;
    int error_cnt = 0;

    reg_bank_viewer #(
        .ADDR_W       (4),
        .DATA_W       (16),
        .DEBOUNCE_CYC (4),
        .SCAN_PERIOD  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .key_next (key_next),
        .key_mode (key_mode),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .display  (display),
        .modo     (modo),
        .auto_led (auto_led)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // combinational bank read port
    assign rd_data = bank[rd_addr];

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        if (observed !== expected) begin
            error_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // clean key_next press; call on a falling edge
    task automatic press_next(input int low_clk, input int high_clk);
        key_next = 1'b0;
        repeat (low_clk) @(negedge clk);
        key_next = 1'b1;
        repeat (high_clk) @(negedge clk);
    endtask

    // clean key_mode press; call on a falling edge
    task automatic press_mode(input int low_clk, input int high_clk);
        key_mode = 1'b0;
        repeat (low_clk) @(negedge clk);
        key_mode = 1'b1;
        repeat (high_clk) @(negedge clk);
    endtask

    // wait (bounded) for rd_addr to leave prev; n = falling edges waited
    task automatic wait_addr_change(input logic [3:0] prev, output int n);
        n = 0;
        while (rd_addr == prev && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // watchdog
    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) begin
            bank[i] = 16'hC000 | 16'(i);
        end
        bank[0]  = 16'h1234;
        bank[3]  = 16'hBEEF;
        reset    = 1'b1;
        tick     = 1'b1;
        key_next = 1'b1;
        key_mode = 1'b1;

        // reset and first capture
        repeat (3) @(negedge clk);
        check_value("rst_display", display, 32'h0000_0000);
        check_value("rst_modo", 32'(modo), 32'h0000_0000);
        check_value("rst_rd_addr", 32'(rd_addr), 32'h0000_0000);
        check_value("rst_auto_led", 32'(auto_led), 32'h0000_0000);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_value("init_display", display, 32'h0000_1234);
        check_value("init_modo", 32'(modo), 32'h0000_00CF);
        check_value("init_rd_addr", 32'(rd_addr), 32'h0000_0000);

        // manual stepping
        press_next(8, 8);
        check_value("step1_addr", 32'(rd_addr), 32'h0000_0001);
        check_value("step1_display", display, 32'h0100_C001);
        press_next(8, 8);
        press_next(8, 8);
        check_value("step3_addr", 32'(rd_addr), 32'h0000_0003);
        check_value("step3_display", display, 32'h0300_BEEF);
        check_value("step3_modo", 32'(modo), 32'h0000_00CF);

        // walk to 15, then wrap to 0
        repeat (12) press_next(8, 8);
        check_value("addr15", 32'(rd_addr), 32'h0000_000F);
        check_value("addr15_display", display, 32'h0F00_C00F);
        press_next(8, 8);
        check_value("wrap_addr", 32'(rd_addr), 32'h0000_0000);
        check_value("wrap_nibble", 32'(display[27:24]), 32'h0000_0000);
        check_value("wrap_display", display, 32'h0000_1234);

        // short bounce must not be accepted
        key_next = 1'b0;
        repeat (2) @(negedge clk);
        key_next = 1'b1;
        repeat (20) @(negedge clk);
        check_value("bounce_addr", 32'(rd_addr), 32'h0000_0000);

        // auto scan; first advance lands 8 ticks after the mode toggle
        press_mode(8, 8);
        check_value("auto_led_on", 32'(auto_led), 32'h0000_0001);
        check_value("auto_nibble", 32'(display[31:28]), 32'h0000_000A);
        check_value("auto_first_addr", 32'(rd_addr), 32'h0000_0001);
        fork
            begin : scan_mon
                logic [3:0] prev_a;
                logic [3:0] exp_a;
                int         n_s;
                prev_a = 4'h1;
                for (int k = 0; k < 17; k++) begin
                    wait_addr_change(prev_a, n_s);
                    exp_a = prev_a + 4'h1;
                    check_value("scan_addr", 32'(rd_addr), 32'(exp_a));
                    if (k > 0) begin
                        check_value("scan_period", 32'(n_s), 32'd8);
                    end
                    prev_a = exp_a;
                end
            end
            begin : ignored_next
                repeat (20) @(negedge clk);
                repeat (3) press_next(8, 8);
            end
        join
        // scan ended showing 2; one more advance fires before the toggle lands
        repeat (2) @(negedge clk);
        press_mode(8, 8);
        check_value("auto_led_off", 32'(auto_led), 32'h0000_0000);
        check_value("manual_nibble", 32'(display[31:28]), 32'h0000_0000);
        check_value("stop_addr", 32'(rd_addr), 32'h0000_0003);
        repeat (40) @(negedge clk);
        check_value("stop_hold_addr", 32'(rd_addr), 32'h0000_0003);

        // live update at address 5
        repeat (2) press_next(8, 8);
        check_value("addr5", 32'(rd_addr), 32'h0000_0005);
        check_value("addr5_display", display, 32'h0500_C005);
        bank[5] = 16'h00FF;
        @(negedge clk);
        check_value("live_data", 32'(display[15:0]), 32'h0000_00FF);

        // debounce is frozen while tick is low
        tick     = 1'b0;
        key_next = 1'b0;
        repeat (12) @(negedge clk);
        key_next = 1'b1;
        repeat (12) @(negedge clk);
        tick = 1'b1;
        repeat (4) @(negedge clk);
        check_value("no_tick_addr", 32'(rd_addr), 32'h0000_0005);

        // simultaneous key_mode and key_next events: mode wins
        key_next = 1'b0;
        key_mode = 1'b0;
        repeat (8) @(negedge clk);
        check_value("collide_auto_led", 32'(auto_led), 32'h0000_0001);
        check_value("collide_addr", 32'(rd_addr), 32'h0000_0005);
        check_value("collide_nibble", 32'(display[31:28]), 32'h0000_000A);
        key_next = 1'b1;
        key_mode = 1'b1;
        repeat (8) @(negedge clk);
        check_value("collide_scan_addr", 32'(rd_addr), 32'h0000_0006);

        // leave auto as a scan advance is taken, then press key_next during
        // SETUP so CAPTURE holds a pending request; reset in that cycle
        wait_addr_change(4'h6, n);
        check_value("pend_sync_addr", 32'(rd_addr), 32'h0000_0007);
        key_mode = 1'b0;
        @(negedge clk);
        key_next = 1'b0;
        repeat (6) @(negedge clk);
        key_mode = 1'b1;
        key_next = 1'b1;
        @(negedge clk);
        check_value("pend_setup_addr", 32'(rd_addr), 32'h0000_0008);
        check_value("pend_manual", 32'(auto_led), 32'h0000_0000);
        reset = 1'b1;
        @(negedge clk);
        check_value("midrst_rd_addr", 32'(rd_addr), 32'h0000_0000);
        check_value("midrst_display", display, 32'h0000_0000);
        check_value("midrst_modo", 32'(modo), 32'h0000_0000);
        check_value("midrst_auto_led", 32'(auto_led), 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_value("post_rst_display", display, 32'h0000_1234);
        check_value("post_rst_modo", 32'(modo), 32'h0000_00CF);
        repeat (30) @(negedge clk);
        check_value("no_stale_addr", 32'(rd_addr), 32'h0000_0000);
        check_value("no_stale_display", display, 32'h0000_1234);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule
